uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered UART transmit path: accepts bytes from an upstream producer over a valid/ready handshake, filters them to the supported character sets (printable English ASCII and Thai TIS-620), queues them in a 16-entry FIFO, and serializes them 8N1 on `RsTx`. It is the send-side counterpart of the receive/echo path and sits between on-board character sources (keypad/switch encoders, message ROMs) and the board's TX pin. It also flags whether the byte currently on the wire is Thai, for display logic.

## Interface
- `OVERSAMPLE`, 16: `baud` ticks per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 16: queue entries; power of two, ≥ 2.
- `baud`  in  1  block clock; the same oversampled baud clock that drives the receiver.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  byte offered by the producer.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  block can consume a byte this cycle.
- `RsTx`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress or FIFO non-empty.
- `is_thai`  out  1  byte in the current frame is in 0xA0–0xFF; held until the next frame starts.
- `dropped`  out  1  one-cycle pulse when a consumed byte is rejected by the filter.

## Operation
- Handshake: a byte is consumed on any cycle with `in_valid & in_ready`. `in_ready = ~full & ~reset`.
- Filter, applied on consume: accept 0x20–0x7E, 0xA0–0xFF, 0x0A, 0x0D. Write accepted bytes to the FIFO. Rejected bytes are consumed and discarded, with `dropped` high for the following cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop, load the shift register, set `is_thai`, and go to START.
  - START: drive 0 for `OVERSAMPLE` cycles, then go to DATA.
  - DATA: drive 8 bits LSB first, `OVERSAMPLE` cycles each, using a 3-bit bit index; then go to STOP.
  - STOP: drive 1 for `OVERSAMPLE` cycles. On its last cycle, if the FIFO is non-empty, pop and go to START (no idle bit between frames); otherwise go to IDLE.
- Counters:
  - Tick counter width `$clog2(OVERSAMPLE)`; it wraps at `OVERSAMPLE-1`.
  - FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
  - Count is one bit wider than the pointers.
- FIFO boundaries:
  - Push and pop on the same cycle leave the count unchanged.
  - No push occurs when full, because `in_ready` is low.
  - No pop occurs when empty.
- `busy = (state != IDLE) | ~empty`.
- Reset: `RsTx`=1, `busy`=0, `is_thai`=0, `dropped`=0, FIFO empty, state IDLE, and `in_ready`=0 while `reset` is high.
- Reset mid-frame: the frame is aborted, `RsTx` returns high on the next cycle, and queued bytes are lost. No partial-frame completion.

## Timing
- `RsTx` is driven from a register; no combinational path from inputs.
- Latency:
  - Byte consumed at cycle N into an empty, idle block.
  - FIFO non-empty at N+1; IDLE pops at N+1.
  - `RsTx` falls at N+2.
- Frame length is exactly `10*OVERSAMPLE` cycles.
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle.
- `dropped` asserts on cycle N+1 for a rejected byte consumed at N.
- `is_thai` updates at the pop cycle, visible from N+2.
- Full at `FIFO_DEPTH` entries: `in_ready` drops the cycle after the push that fills the FIFO. It rises the cycle after the first pop.

## Structure
- Shared package `uart_pkg`:
  - Character-range constants: `ASCII_LO`=0x20, `ASCII_HI`=0x7E, `THAI_LO`=0xA0, `THAI_HI`=0xFF, `CH_LF`, `CH_CR`.
  - A `char_ok()` function, also reused by the receive-side echo logic.
  - The TX state enum.
- Sub-module `uart_byte_fifo`: synchronous FIFO with `wr_en/rd_en/full/empty/count` and parameterised depth. Its read data must be valid in the pop cycle (first-word fall-through).
- Top level holds the filter, FSM, tick/bit counters and shift register.

## Test plan
- Reset, then push 0x41 with `OVERSAMPLE`=4 → `RsTx` high during reset. From N+2: 0 for 4 cycles, then bits 1,0,0,0,0,0,1,0 (4 cycles each), then 1 for 4 cycles. `is_thai`=0; `busy` falls after 40 cycles.
- Push 0xE0 (Thai) → frame LSB-first 0,0,0,0,0,1,1,1. `is_thai`=1 from N+2 and stays 1 after the frame ends.
- Push 0x07, 0x7F, 0x9F → all consumed with `in_ready`=1. Three `dropped` pulses, `RsTx` stays high, `busy` stays 0.
- Hold `in_valid` with 20 valid bytes 0x30–0x43 → `in_ready` low after the 16th is queued while the first frame is in flight. All 20 bytes appear in order with no gaps between frames (200·`OVERSAMPLE` cycles total from the first start bit).
- Assert `reset` mid-DATA of 0x55 with 3 bytes queued → `RsTx`=1 the next cycle, `busy`=0. No further frames after release.
- Push 0x0D and 0x0A → both transmitted; `dropped` never asserts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: character-set limits, the character filter used by
// both the transmit queue and the receive-side echo, and the TX state type.
package uart_pkg;

    // Printable English ASCII range
    localparam logic [7:0] ASCII_LO = 8'h20;
    localparam logic [7:0] ASCII_HI = 8'h7E;

    // Thai TIS-620 range (upper half of the byte space)
    localparam logic [7:0] THAI_LO  = 8'hA0;
    localparam logic [7:0] THAI_HI  = 8'hFF;

    // Line-control characters that are let through the filter
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    // Serializer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Inclusive range test, kept generic so callers never compare against
    // a bound that is already the edge of the byte range
    function automatic logic in_range(input logic [7:0] ch,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (ch >= lo) && (ch <= hi);
    endfunction

    // True when the byte belongs to the Thai half of the character set
    function automatic logic is_thai_char(input logic [7:0] ch);
        return in_range(ch, THAI_LO, THAI_HI);
    endfunction

    // True for any byte the board is allowed to put on the wire
    function automatic logic char_ok(input logic [7:0] ch);
        return in_range(ch, ASCII_LO, ASCII_HI) ||
               is_thai_char(ch)                 ||
               (ch == CH_LF)                    ||
               (ch == CH_CR);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte queue with first-word fall-through read data: the entry at
// the head is always visible on rd_data_o, so the consumer can use it in the
// same cycle it pops. Pushes while full and pops while empty are ignored.
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push;
    logic             pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rdPtr_q];

    assign push = wr_en_i & ~full_o;
    assign pop  = rd_en_i & ~empty_o;

    // Occupancy follows push/pop; simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wrPtr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 transmitter: filters incoming bytes to the supported character
// sets, queues accepted ones, and serializes them back to back on RsTx. Each
// serial bit lasts OVERSAMPLE cycles of the oversampled baud clock.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       baud,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       RsTx,
    output logic       busy,
    output logic       is_thai,
    output logic       dropped
);

    localparam int TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    tx_state_e         state_q;
    logic              tx_q;
    logic [TICK_W-1:0] tickCnt_q;
    logic [2:0]        bitIdx_q;
    logic [7:0]        shiftReg_q;
    logic              isThai_q;
    logic              dropped_q;

    logic              consume;
    logic              charAccepted;
    logic              accept;
    logic              reject;
    logic              tickLast;
    logic              popNow;
    logic [7:0]        fifoRdData;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [CNT_W-1:0]  fifoCount;

    // Producer handshake and character filter
    assign in_ready     = ~fifoFull & ~reset;
    assign consume      = in_valid & in_ready;
    assign charAccepted = char_ok(in_data);
    assign accept       = consume & charAccepted;
    assign reject       = consume & ~charAccepted;

    // A new frame is fetched from idle, or on the last stop-bit cycle so that
    // consecutive frames leave no idle bit between them
    assign tickLast = (tickCnt_q == TICK_LAST);
    assign popNow   = ~fifoEmpty &
                      ((state_q == IDLE) | ((state_q == STOP) & tickLast));

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i     (baud),
        .reset_i   (reset),
        .wr_en_i   (accept),
        .wr_data_i (in_data),
        .rd_en_i   (popNow),
        .rd_data_o (fifoRdData),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty),
        .count_o   (fifoCount)
    );

    // Frame sequencer: start bit, eight data bits LSB first, stop bit; the
    // line level is registered so RsTx never sees a combinational path
    always_ff @(posedge baud) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            tickCnt_q  <= '0;
            bitIdx_q   <= '0;
            shiftReg_q <= '0;
            isThai_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tickCnt_q <= '0;
                    bitIdx_q  <= '0;
                    if (popNow) begin
                        state_q    <= START;
                        tx_q       <= 1'b0;
                        shiftReg_q <= fifoRdData;
                        isThai_q   <= is_thai_char(fifoRdData);
                    end
                end
                START: begin
                    if (tickLast) begin
                        state_q    <= DATA;
                        tickCnt_q  <= '0;
                        bitIdx_q   <= '0;
                        tx_q       <= shiftReg_q[0];
                        shiftReg_q <= {1'b0, shiftReg_q[7:1]};
                    end else begin
                        tickCnt_q <= tickCnt_q + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tickLast) begin
                        tickCnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bitIdx_q   <= bitIdx_q + 3'd1;
                            tx_q       <= shiftReg_q[0];
                            shiftReg_q <= {1'b0, shiftReg_q[7:1]};
                        end
                    end else begin
                        tickCnt_q <= tickCnt_q + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tickLast) begin
                        tickCnt_q <= '0;
                        bitIdx_q  <= '0;
                        if (popNow) begin
                            state_q    <= START;
                            tx_q       <= 1'b0;
                            shiftReg_q <= fifoRdData;
                            isThai_q   <= is_thai_char(fifoRdData);
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        tickCnt_q <= tickCnt_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // One-cycle pulse for every consumed byte the filter throws away
    always_ff @(posedge baud) begin
        if (reset) begin
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= reject;
        end
    end

    assign RsTx    = tx_q;
    assign is_thai = isThai_q;
    assign dropped = dropped_q;
    assign busy    = (state_q != IDLE) | (fifoCount != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed steps plus a random burst, checked by
// a serial-line monitor that decodes every frame against the queue of bytes
// the filter should have accepted.
module tb_uart_tx_buffered;

    localparam int OS    = 4;
    localparam int DEPTH = 16;

    logic       baud;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       RsTx;
    logic       busy;
    logic       is_thai;
    logic       dropped;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;

    logic [7:0] expQ [$];
    logic       expDropNext = 1'b0;
    int         dropSeen    = 0;
    int         acceptCount = 0;

    int         obsCyc;
    logic       obsTx, obsBusy, obsThai, obsReady;
    logic       lastConsumed;

    bit         inFrame    = 1'b0;
    int         frameT     = 0;
    int         frameCount = 0;
    logic [7:0] curByte;
    int         monBitNo;
    logic       monExpBit;

    int n0, stallCyc, backCyc, stallIdx, idx, lowCyc, k;
    int frameBase, acceptBase, dropBase;
    logic [7:0] dropBytes [3];
    logic [7:0] rndByte;
    logic       rndValid;

    uart_tx_buffered #(
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .baud     (baud),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .RsTx     (RsTx),
        .busy     (busy),
        .is_thai  (is_thai),
        .dropped  (dropped)
    );

    initial baud = 1'b0;
    always #5 baud = ~baud;

    always @(posedge baud) cyc++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Filter rule written from the character-set definition
    function automatic bit charOk(input logic [7:0] c);
        return ((c >= 8'h20) && (c <= 8'h7E)) || (c >= 8'hA0) ||
               (c == 8'h0A) || (c == 8'h0D);
    endfunction

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample outputs mid-cycle, update the model
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(negedge baud);
        obsCyc       = cyc;
        obsTx        = RsTx;
        obsBusy      = busy;
        obsThai      = is_thai;
        obsReady     = in_ready;
        lastConsumed = v & (in_ready === 1'b1);
        checkOutput("dropped", dropped, expDropNext);
        if (dropped === 1'b1) dropSeen++;
        @(posedge baud);
        #1;
        if (reset) begin
            expDropNext = 1'b0;
        end else begin
            expDropNext = lastConsumed & !charOk(d);
            if (lastConsumed && charOk(d)) begin
                expQ.push_back(d);
                acceptCount++;
            end
        end
    endtask

    task automatic waitIdle(input int budget, output int lowAt);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end while (obsBusy !== 1'b0 && n < budget);
        checkOutput("idle_reached", obsBusy, 1'b0);
        lowAt = obsCyc;
    endtask

    // Serial-line monitor: decodes each frame and compares it with the next
    // byte the filter should have accepted; a reset discards everything
    always @(negedge baud) begin
        if (reset === 1'b1) begin
            inFrame = 1'b0;
            expQ.delete();
        end else if (inFrame || RsTx === 1'b0) begin
            if (!inFrame) begin
                inFrame = 1'b1;
                frameT  = 0;
                frameCount++;
                checkOutput("frame_expected", expQ.size() != 0, 1'b1);
                if (expQ.size() != 0) curByte = expQ.pop_front();
                else curByte = 8'hxx;
            end
            monBitNo = frameT / OS;
            if (monBitNo == 0)      monExpBit = 1'b0;
            else if (monBitNo == 9) monExpBit = 1'b1;
            else                    monExpBit = curByte[3'(monBitNo - 1)];
            checkOutput("frame_line", RsTx, monExpBit);
            checkOutput("frame_is_thai", is_thai, curByte >= 8'hA0);
            frameT++;
            if (frameT == 10 * OS) inFrame = 1'b0;
        end
    end

    initial begin
        dropBytes = '{8'h07, 8'h7F, 8'h9F};
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        repeat (2) @(posedge baud);
        #1;

        // Reset state, with a byte offered that must not be taken
        applyStimulus(1'b1, 8'h41);
        checkOutput("rst_in_ready", obsReady, 1'b0);
        checkOutput("rst_tx", obsTx, 1'b1);
        checkOutput("rst_busy", obsBusy, 1'b0);
        checkOutput("rst_thai", obsThai, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkOutput("rst_nothing_queued", obsBusy, 1'b0);
        checkOutput("rst_ready_after", obsReady, 1'b1);

        // Single ASCII byte from idle: latency and frame length
        applyStimulus(1'b1, 8'h41);
        checkOutput("p2_consumed", lastConsumed, 1'b1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("p2_tx_n1", obsTx, 1'b1);
        checkOutput("p2_busy_n1", obsBusy, 1'b1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("p2_tx_n2", obsTx, 1'b0);
        checkOutput("p2_thai_n2", obsThai, 1'b0);
        k = 2;
        while (obsBusy !== 1'b0 && k < 200) begin
            applyStimulus(1'b0, 8'h00);
            k++;
        end
        checkCount("p2_busy_fall", k, 10 * OS + 2);
        checkCount("p2_drained", expQ.size(), 0);

        // Thai byte: flag rises with the start bit and is held afterwards
        applyStimulus(1'b1, 8'hE0);
        checkOutput("p3_consumed", lastConsumed, 1'b1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("p3_thai_n1", obsThai, 1'b0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("p3_thai_n2", obsThai, 1'b1);
        checkOutput("p3_tx_n2", obsTx, 1'b0);
        waitIdle(200, lowCyc);
        checkOutput("p3_thai_held", obsThai, 1'b1);

        // Rejected bytes: consumed, pulsed on dropped, never transmitted
        dropBase = dropSeen;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, dropBytes[i]);
            checkOutput("p4_consumed", lastConsumed, 1'b1);
            checkOutput("p4_tx", obsTx, 1'b1);
            checkOutput("p4_busy", obsBusy, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00);
            checkOutput("p4_tx_after", obsTx, 1'b1);
            checkOutput("p4_busy_after", obsBusy, 1'b0);
        end
        checkCount("p4_drop_pulses", dropSeen - dropBase, 3);
        checkOutput("p4_thai_held", obsThai, 1'b1);

        // Held-valid burst of 20 bytes: back-pressure and gapless frames
        idx = 0; n0 = -1; stallCyc = -1; backCyc = -1; stallIdx = -1;
        for (int i = 0; i < 3000 && idx < 20; i++) begin
            applyStimulus(1'b1, 8'h30 + 8'(idx));
            if (lastConsumed) begin
                if (idx == 0) n0 = obsCyc;
                idx++;
            end else if (stallCyc < 0) begin
                stallCyc = obsCyc;
                stallIdx = idx;
            end
            if (stallCyc >= 0 && backCyc < 0 && obsReady === 1'b1) backCyc = obsCyc;
        end
        checkCount("p5_all_consumed", idx, 20);
        checkCount("p5_taken_before_stall", stallIdx, DEPTH + 1);
        checkCount("p5_ready_return", backCyc - n0, 10 * OS + 2);
        waitIdle(3000, lowCyc);
        checkCount("p5_total_span", lowCyc - n0, 200 * OS + 2);
        checkCount("p5_drained", expQ.size(), 0);

        // Reset in the middle of a data bit with three bytes still queued
        applyStimulus(1'b1, 8'h55);
        applyStimulus(1'b1, 8'h41);
        applyStimulus(1'b1, 8'h42);
        applyStimulus(1'b1, 8'h43);
        checkOutput("p6_consumed", lastConsumed, 1'b1);
        repeat (10) applyStimulus(1'b0, 8'h00);
        checkOutput("p6_in_frame", obsBusy, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00);
        checkOutput("p6_tx_after_reset", obsTx, 1'b1);
        checkOutput("p6_busy_after_reset", obsBusy, 1'b0);
        checkOutput("p6_thai_after_reset", obsThai, 1'b0);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 8'h00);
            checkOutput("p6_quiet_tx", obsTx, 1'b1);
            checkOutput("p6_quiet_busy", obsBusy, 1'b0);
        end

        // CR and LF pass the filter
        frameBase = frameCount;
        dropBase  = dropSeen;
        applyStimulus(1'b1, 8'h0D);
        applyStimulus(1'b1, 8'h0A);
        waitIdle(300, lowCyc);
        checkCount("p7_frames", frameCount - frameBase, 2);
        checkCount("p7_no_drops", dropSeen - dropBase, 0);
        checkCount("p7_drained", expQ.size(), 0);

        // Random traffic through the filter and queue
        frameBase  = frameCount;
        acceptBase = acceptCount;
        for (int i = 0; i < 40; i++) begin
            rndValid = ($urandom_range(0, 3) != 0);
            rndByte  = 8'($urandom_range(0, 255));
            applyStimulus(rndValid, rndByte);
        end
        waitIdle(4000, lowCyc);
        checkCount("p8_frames", frameCount - frameBase, acceptCount - acceptBase);
        checkCount("p8_drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
